// File: rtl/cmd_arbiter.sv
// cmd_arbiter: shares one SD command physical controller between two requesters
// (port 0 = software register path, port 1 = data-path controller).
// Round-robin grant, strobe/ack/idle sequencing toward the physical path,
// response-timeout watchdog with abort, registered response return.
// Optional build macro CMD_ARB_RETRY_EN: one automatic reissue after the
// first timeout of a transaction; only a second timeout is reported.
//
// Handshake summary: a requester raises req_valid[i] with req_cmd stable and
// keeps it high until resp_valid[i]; resp_valid[i] (with resp_data and
// resp_timeout) then stays high until req_ack[i] is seen, after which the
// requester is free to present a new command.
module cmd_arbiter #(
   parameter int CMD_W          = 40,
   parameter int RESP_W         = 136,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int TO_W           = 7
) (
   input  logic              sd_clock,
   input  logic              reset,
   input  logic [1:0]        req_valid,
   input  logic [CMD_W-1:0]  req_cmd0,
   input  logic [CMD_W-1:0]  req_cmd1,
   input  logic [1:0]        req_ack,
   output logic [1:0]        resp_valid,
   output logic [RESP_W-1:0] resp_data,
   output logic              resp_timeout,
   output logic              busy,
   output logic [CMD_W-1:0]  phys_cmd,
   output logic              phys_strobe,
   output logic              phys_ack,
   output logic              phys_idle,
   input  logic              phys_resp_strobe,
   input  logic [RESP_W-1:0] phys_response,
   output logic [2:0]        fsm_state
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_RESP = 3'd2,
      PHYS_ACK  = 3'd3,
      ABORT     = 3'd4,
      DELIVER   = 3'd5
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t          cur_state;
   state_t          nxt_state;
   logic [TO_W-1:0] to_cnt;
   logic            grant;
   logic            rr_ptr;
   logic            grant_sel;
   logic            strobe_d;
   logic            ack_d;
   logic            idle_d;
   logic            busy_d;
   logic [1:0]      resp_valid_d;
`ifdef CMD_ARB_RETRY_EN
   logic            retry;
`endif

   assign fsm_state = cur_state;

   // Winner among current requests: round-robin pointer breaks a tie.
   always_comb begin
      grant_sel = 1'b0;
      if (req_valid == 2'b11) grant_sel = rr_ptr;
      else                    grant_sel = req_valid[1];
   end

   // State register.
   always_ff @(posedge sd_clock) begin
      if (!reset) cur_state <= IDLE;
      else        cur_state <= nxt_state;
   end

   // Next-state logic; a response on the terminal count cycle beats the abort.
   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         IDLE:      if (|req_valid) nxt_state = ISSUE;
         ISSUE:     nxt_state = WAIT_RESP;
         WAIT_RESP: begin
            if (phys_resp_strobe)      nxt_state = PHYS_ACK;
            else if (to_cnt == TO_LAST) nxt_state = ABORT;
         end
         PHYS_ACK:  nxt_state = DELIVER;
`ifdef CMD_ARB_RETRY_EN
         ABORT:     nxt_state = retry ? DELIVER : ISSUE;
`else
         ABORT:     nxt_state = DELIVER;
`endif
         DELIVER:   if (req_ack[grant]) nxt_state = IDLE;
         default:   nxt_state = IDLE;
      endcase
   end

   // Output decode from the next state so registered outputs line up with the state.
   always_comb begin
      strobe_d     = (nxt_state == ISSUE);
      ack_d        = (nxt_state == PHYS_ACK);
      idle_d       = (nxt_state == ABORT);
      busy_d       = (nxt_state != IDLE);
      resp_valid_d = 2'b00;
      if (nxt_state == DELIVER) resp_valid_d = grant ? 2'b10 : 2'b01;
   end

   // Output registers, grant/command latch, watchdog counter and response capture.
   always_ff @(posedge sd_clock) begin
      if (!reset) begin
         phys_strobe  <= 1'b0;
         phys_ack     <= 1'b0;
         phys_idle    <= 1'b0;
         busy         <= 1'b0;
         resp_valid   <= 2'b00;
         resp_data    <= '0;
         resp_timeout <= 1'b0;
         phys_cmd     <= '0;
         to_cnt       <= '0;
         grant        <= 1'b0;
         rr_ptr       <= 1'b0;
      end else begin
         phys_strobe <= strobe_d;
         phys_ack    <= ack_d;
         phys_idle   <= idle_d;
         busy        <= busy_d;
         resp_valid  <= resp_valid_d;
         if (cur_state == IDLE && |req_valid) begin
            grant    <= grant_sel;
            phys_cmd <= grant_sel ? req_cmd1 : req_cmd0;
         end
         if (cur_state == ISSUE)          to_cnt <= '0;
         else if (cur_state == WAIT_RESP) to_cnt <= to_cnt + 1'b1;
         if (cur_state == WAIT_RESP && phys_resp_strobe) begin
            resp_data    <= phys_response;
            resp_timeout <= 1'b0;
         end else if (nxt_state == ABORT) begin
            resp_data    <= '0;
            resp_timeout <= 1'b1;
         end
         if (cur_state == DELIVER && req_ack[grant]) rr_ptr <= ~grant;
      end
   end

`ifdef CMD_ARB_RETRY_EN
   // Retry flag: set by the first abort, cleared whenever the arbiter is idle.
   always_ff @(posedge sd_clock) begin
      if (!reset)                  retry <= 1'b0;
      else if (cur_state == IDLE)  retry <= 1'b0;
      else if (cur_state == ABORT) retry <= 1'b1;
   end
`endif

endmodule

// File: doc/cmd_arbiter.md
Name: cmd_arbiter

Overview:
- Shares the single SD command physical controller between two command requesters: port 0 is the software register path; port 1 is the data-path controller (auto CMD12/CMD13).
- Grants round-robin and sequences the physical controller's strobe/ack/idle handshake.
- Runs a response-timeout watchdog that aborts the physical controller on timeout.
- Returns the captured response, or a timeout flag, to the granted requester.

Parameters:
- CMD_W, 40, width of command word (index + argument) forwarded to the physical path
- RESP_W, 136, width of response word
- TIMEOUT_CYCLES, 64, sd_clock cycles in WAIT_RESP before abort; legal range 2..127
- TO_W, 7, width of timeout counter

Ports:
- sd_clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  2  per requester; held high with req_cmd stable until that requester's resp_valid
- req_cmd0  in  CMD_W  requester 0 command
- req_cmd1  in  CMD_W  requester 1 command
- req_ack  in  2  per requester; response-consumed acknowledge
- resp_valid  out  2  per requester; response/timeout available, held until matching req_ack
- resp_data  out  RESP_W  captured response, shared by both requesters
- resp_timeout  out  1  qualifies resp_valid: 1 means no response was received
- busy  out  1  high in every state except IDLE
- phys_cmd  out  CMD_W  command to physical path; stable from ISSUE until DELIVER exits
- phys_strobe  out  1  drives controller strobe_in
- phys_ack  out  1  drives controller ack_in
- phys_idle  out  1  drives controller idle_in (abort)
- phys_resp_strobe  in  1  controller strobe_out, response received
- phys_response  in  RESP_W  controller response

Behaviour:
- Reset (reset==0 at an edge):
  - State goes to IDLE; grant pointer goes to requester 0.
  - All outputs are 0, including resp_data, phys_cmd and the timeout counter.
  - Reset takes effect mid-transaction too; no phys_idle pulse is generated by reset.
- States: IDLE, ISSUE, WAIT_RESP, PHYS_ACK, ABORT, DELIVER. State and all outputs are registered.
- IDLE:
  - If any req_valid bit is set, grant: with both set, the requester selected by rr_ptr wins; with one set, that one wins.
  - On grant, latch grant id and its command into phys_cmd, then go to ISSUE.
  - Grant-to-phys_strobe latency is 1 cycle.
- ISSUE: phys_strobe=1 for exactly one cycle; clear the timeout counter; go to WAIT_RESP.
- WAIT_RESP:
  - The counter increments by 1 each cycle.
  - If phys_resp_strobe==1, capture phys_response into resp_data, set resp_timeout=0, go to PHYS_ACK.
  - Otherwise, when the counter equals TIMEOUT_CYCLES-1, go to ABORT.
  - If phys_resp_strobe arrives on the terminal count cycle, the response wins and there is no abort.
- PHYS_ACK: phys_ack=1 for exactly one cycle; go to DELIVER.
- ABORT: phys_idle=1 for exactly one cycle; resp_data=0; resp_timeout=1; go to DELIVER (or back to ISSUE under the optional feature).
- DELIVER:
  - resp_valid[grant]=1; the other resp_valid bit stays 0.
  - Wait for req_ack[grant]. req_ack on the non-granted bit is ignored.
  - On ack: clear resp_valid, set rr_ptr = ~grant, go to IDLE.
  - A new grant is possible in the cycle after the return to IDLE.
- Requester behaviour during a transaction:
  - If req_valid drops mid-transaction, it is ignored; the transaction completes and is still delivered.
  - A new req_valid from the non-granted requester waits.
- phys_resp_strobe outside WAIT_RESP is ignored.
- resp_data and resp_timeout hold their value after DELIVER until the next capture or abort.
- Minimum transaction with response on the first WAIT_RESP cycle and an immediate ack: IDLE→ISSUE→WAIT_RESP→PHYS_ACK→DELIVER→IDLE, 5 cycles.

Optional Feature:
- Macro: CMD_ARB_RETRY_EN.
- Defined:
  - After the first ABORT of a transaction, a one-bit retry flag is set and the FSM returns to ISSUE, reissuing the same phys_cmd with a fresh timeout window.
  - Only a second timeout goes to DELIVER with resp_timeout=1.
  - The retry flag clears in IDLE.
  - A timed-out-then-retried transaction produces two phys_strobe pulses and two phys_idle pulses only if both attempts time out.
- Not defined: no retry flag exists; ABORT always goes to DELIVER.

Test Plan:
- Single request, no retry:
  - Stimulus: reset low 2 cycles; req_valid=01, req_cmd0=0x0C00000000; phys_resp_strobe on 3rd WAIT_RESP cycle with phys_response=0xAB.
  - Required: one phys_strobe pulse, phys_cmd=0x0C00000000, one phys_ack pulse, resp_valid=01, resp_data=0xAB, resp_timeout=0.
- Contention:
  - Stimulus: req_valid=11 continuously, immediate acks.
  - Required: grants alternate 0,1,0,1; resp_valid seen as 01,10,01,10.
- Timeout:
  - Stimulus: no phys_resp_strobe, TIMEOUT_CYCLES=64.
  - Required: phys_idle pulses exactly 64 cycles after WAIT_RESP entry; resp_timeout=1, resp_data=0; with CMD_ARB_RETRY_EN, two phys_strobe pulses before resp_valid.
- Race at terminal count:
  - Stimulus: phys_resp_strobe on cycle 64 of WAIT_RESP.
  - Required: no phys_idle pulse; resp_timeout=0; response captured.
- Ack hold and misdirected ack:
  - Stimulus: req_ack withheld for 10 cycles after DELIVER entry; req_ack=10 pulsed while requester 0 is granted.
  - Required: resp_valid=01 held for all 10 cycles; busy=1 throughout; the misdirected ack is ignored.
- Reset mid-transaction:
  - Stimulus: reset low during WAIT_RESP.
  - Required: next cycle all outputs 0, state IDLE; after release with req_valid=11, requester 0 is granted first.
